// File: rtl/idct_block_writer_pkg.sv
// ---------------------------------------------------------------------------
// idct_block_writer_pkg
//   Shared definitions for the IDCT block write-back path: the block-writer
//   state enum, DPRAM / SRAM layout constants (result region offset, row
//   length, Y/U/V plane bases) and the SRAM word-address helper that maps a
//   block position plus word index onto the raster-ordered plane.
// ---------------------------------------------------------------------------
package idct_block_writer_pkg;

    // DPRAM word address of IDCT result element 0.
    localparam logic [8:0]  DPRAM_RESULT_OFFSET = 9'd192;

    // Words per image row (320 pixels, two pixels per 16-bit word).
    localparam logic [15:0] ROW_LENGTH = 16'd160;

    // Plane base word addresses in SRAM.
    localparam logic [17:0] Y_OFFSET = 18'd0;
    localparam logic [17:0] U_OFFSET = 18'd38400;
    localparam logic [17:0] V_OFFSET = 18'd57600;

    // Block grid of one plane.
    localparam logic [5:0]  NUM_BLOCK_COLS = 6'd40;
    localparam logic [4:0]  NUM_BLOCK_ROWS = 5'd30;

    typedef enum logic [2:0] {
        S_BW_IDLE,
        S_BW_LEAD,
        S_BW_EVEN,
        S_BW_ODD,
        S_BW_DONE
    } state_block_writer;

    // Word k of a block (k = 0..31) covers pixel row k>>2, word column k&3.
    // All arithmetic is carried out at the full 18-bit SRAM address width.
    function automatic logic [17:0] block_word_addr(
        input logic [17:0] base,
        input logic [15:0] row_words,
        input logic [4:0]  block_row,
        input logic [5:0]  block_col,
        input logic [4:0]  k
    );
        logic [17:0] line;
        logic [17:0] col_word;
        line     = {10'd0, block_row, 3'd0} + {15'd0, k[4:2]};
        col_word = {10'd0, block_col, 2'd0} + {16'd0, k[1:0]};
        return base + line * {2'd0, row_words} + col_word;
    endfunction

endpackage

// File: rtl/idct_block_writer_if.sv
// ---------------------------------------------------------------------------
// idct_block_writer_if
//   Bundles the block writer's request handshake, DPRAM read port and SRAM
//   write port.
//   Modports:
//     slave  - the block writer itself
//     master - the requester / memory side (IDCT control, DPRAM, SRAM)
//   Signals:
//     start, block_col[5:0], block_row[4:0]   request
//     busy, done                              status
//     DPRAM_read_address[8:0], DPRAM_read_data[31:0]
//     SRAM_address[17:0], SRAM_write_data[15:0], SRAM_we_n
//     checksum[15:0]                          only with BLOCK_WRITER_CHECKSUM_EN
// ---------------------------------------------------------------------------
interface idct_block_writer_if;

    logic        start;
    logic [5:0]  block_col;
    logic [4:0]  block_row;
    logic        busy;
    logic        done;
    logic [8:0]  DPRAM_read_address;
    logic [31:0] DPRAM_read_data;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;

`ifdef BLOCK_WRITER_CHECKSUM_EN
    logic [15:0] checksum;

    modport slave (
        input  start, block_col, block_row, DPRAM_read_data,
        output busy, done, DPRAM_read_address,
               SRAM_address, SRAM_write_data, SRAM_we_n, checksum
    );

    modport master (
        output start, block_col, block_row, DPRAM_read_data,
        input  busy, done, DPRAM_read_address,
               SRAM_address, SRAM_write_data, SRAM_we_n, checksum
    );
`else
    modport slave (
        input  start, block_col, block_row, DPRAM_read_data,
        output busy, done, DPRAM_read_address,
               SRAM_address, SRAM_write_data, SRAM_we_n
    );

    modport master (
        output start, block_col, block_row, DPRAM_read_data,
        input  busy, done, DPRAM_read_address,
               SRAM_address, SRAM_write_data, SRAM_we_n
    );
`endif

endinterface

// File: rtl/idct_block_writer_clipper.sv
// ---------------------------------------------------------------------------
// idct_block_writer_clipper
//   Saturates a signed 16-bit IDCT result (integer part of the 32-bit
//   fixed-point value) to an unsigned 8-bit pixel.
//   Ports:
//     value  in  16  signed integer part
//     pixel  out  8  0 if negative, 255 if above 255, else value[7:0]
// ---------------------------------------------------------------------------
module idct_block_writer_clipper (
    input  logic [15:0] value,
    output logic [7:0]  pixel
);

    always_comb begin
        if (value[15]) begin
            pixel = 8'd0;
        end else if (value[14:8] != 7'd0) begin
            pixel = 8'd255;
        end else begin
            pixel = value[7:0];
        end
    end

endmodule

// File: rtl/idct_block_writer.sv
// ---------------------------------------------------------------------------
// idct_block_writer
//   Write-back end of the IDCT block path. Reads the 64 results of one 8x8
//   block from the DPRAM result region, clips each to 8 bits, packs pixel
//   pairs {even, odd} into 16-bit words and writes the 32 words of the block
//   into the SRAM plane at the block's raster position.
//   Ports:
//     Clock_50   in  system clock
//     Resetn     in  asynchronous active-low reset
//     bw         idct_block_writer_if.slave (request, status, DPRAM read
//                port, SRAM write port)
//   Build option:
//     BLOCK_WRITER_CHECKSUM_EN - adds bw.checksum, the mod-2^16 sum of all
//     words written for the last accepted block.
// ---------------------------------------------------------------------------
module idct_block_writer
    import idct_block_writer_pkg::*;
#(
    parameter logic [17:0] SRAM_BASE     = Y_OFFSET,
    parameter logic [15:0] ROW_WORDS     = ROW_LENGTH,
    parameter logic [8:0]  RESULT_OFFSET = DPRAM_RESULT_OFFSET,
    parameter logic [5:0]  BLOCK_COLS    = NUM_BLOCK_COLS,
    parameter logic [4:0]  BLOCK_ROWS    = NUM_BLOCK_ROWS
) (
    input logic              Clock_50,
    input logic              Resetn,
    idct_block_writer_if.slave bw
);

    localparam logic [8:0] RESULT_LAST = RESULT_OFFSET + 9'd63;

    state_block_writer state, state_next;

    logic [5:0] col_q;
    logic [4:0] row_q;
    logic [4:0] word_idx;
    logic [7:0] even_px;
    logic [7:0] clip_px;
    logic [8:0] rd_addr;
    logic [8:0] rd_addr_next;
    logic       start_ok;

    assign start_ok = bw.start && (bw.block_col < BLOCK_COLS) && (bw.block_row < BLOCK_ROWS);

    // The read address runs one element ahead of the data; it saturates at
    // the last result so the port never leaves the result region.
    assign rd_addr_next = (rd_addr == RESULT_LAST) ? rd_addr : rd_addr + 9'd1;

    assign bw.DPRAM_read_address = rd_addr;

    idct_block_writer_clipper u_clipper (
        .value (bw.DPRAM_read_data[31:16]),
        .pixel (clip_px)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            state <= S_BW_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            col_q    <= 6'd0;
            row_q    <= 5'd0;
            word_idx <= 5'd0;
            even_px  <= 8'd0;
            rd_addr  <= RESULT_OFFSET;
        end else begin
            case (state)
                S_BW_IDLE: begin
                    if (start_ok) begin
                        col_q    <= bw.block_col;
                        row_q    <= bw.block_row;
                        word_idx <= 5'd0;
                        rd_addr  <= RESULT_OFFSET;
                    end
                end
                S_BW_LEAD: begin
                    rd_addr <= rd_addr_next;
                end
                S_BW_EVEN: begin
                    even_px <= clip_px;
                    rd_addr <= rd_addr_next;
                end
                S_BW_ODD: begin
                    word_idx <= word_idx + 5'd1;
                    rd_addr  <= rd_addr_next;
                end
                S_BW_DONE: begin
                    rd_addr <= RESULT_OFFSET;
                end
                default: begin
                    rd_addr <= RESULT_OFFSET;
                end
            endcase
        end
    end

    // SRAM strobe, data and address are decoded from the state so that an
    // asynchronous reset releases we_n in the same instant it clears state.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the
        // case leaves a signal unassigned and no latch is inferred.
        state_next         = state;
        bw.busy            = 1'b0;
        bw.done            = 1'b0;
        bw.SRAM_we_n       = 1'b1;
        bw.SRAM_address    = 18'd0;
        bw.SRAM_write_data = 16'd0;

        case (state)
            S_BW_IDLE: begin
                // An out-of-range request is rejected straight to DONE.
                if (bw.start) begin
                    state_next = start_ok ? S_BW_LEAD : S_BW_DONE;
                end
            end
            S_BW_LEAD: begin
                bw.busy    = 1'b1;
                state_next = S_BW_EVEN;
            end
            S_BW_EVEN: begin
                bw.busy    = 1'b1;
                state_next = S_BW_ODD;
            end
            S_BW_ODD: begin
                bw.busy            = 1'b1;
                bw.SRAM_we_n       = 1'b0;
                bw.SRAM_write_data = {even_px, clip_px};
                bw.SRAM_address    = block_word_addr(SRAM_BASE, ROW_WORDS, row_q, col_q, word_idx);
                state_next         = (word_idx == 5'd31) ? S_BW_DONE : S_BW_EVEN;
            end
            S_BW_DONE: begin
                bw.done    = 1'b1;
                state_next = S_BW_IDLE;
            end
            default: begin
                state_next = S_BW_IDLE;
            end
        endcase
    end

`ifdef BLOCK_WRITER_CHECKSUM_EN
    logic [15:0] checksum_q;

    // Cleared only by an accepted start, so a rejected request leaves the
    // previous block's sum visible.
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            checksum_q <= 16'd0;
        end else if (state == S_BW_IDLE && start_ok) begin
            checksum_q <= 16'd0;
        end else if (state == S_BW_ODD) begin
            checksum_q <= checksum_q + bw.SRAM_write_data;
        end
    end

    assign bw.checksum = checksum_q;
`endif

endmodule

// File: tb/tb_idct_block_writer.sv
// ---------------------------------------------------------------------------
// tb_idct_block_writer
//   Scoreboard bench for idct_block_writer. A DPRAM model (1-cycle read
//   latency) feeds the DUT; the stimulus side computes the expected SRAM
//   words and per-block results from the pixel rules with plain integer
//   arithmetic and queues them; a monitor on the falling edge pops and
//   compares every SRAM write and every done pulse.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_idct_block_writer;

    localparam int RES_OFF   = 192;
    localparam int ROW_WORDS = 160;
    localparam int N_COLS    = 40;
    localparam int N_ROWS    = 30;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int delta;
        int writes;
        int rd_max;
        int csum;
        bit busy_expected;
    } blk_t;

    logic Clock_50 = 1'b0;
    logic Resetn   = 1'b0;

    idct_block_writer_if bw();

    idct_block_writer dut (
        .Clock_50 (Clock_50),
        .Resetn   (Resetn),
        .bw       (bw)
    );

    always #10 Clock_50 = ~Clock_50;

    // ---------------- memory models ----------------
    logic [31:0] dpram [0:511];
    logic [15:0] sram  [int];

    always @(posedge Clock_50) bw.DPRAM_read_data <= dpram[bw.DPRAM_read_address];

    // ---------------- bookkeeping ----------------
    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    wr_t  exp_wr_q[$];
    blk_t exp_blk_q[$];

    int start_mark  = 0;
    int blk_writes  = 0;
    int busy_cnt    = 0;
    int rd_max      = 0;
    int max_wr_addr = -1;
    int first_lat   = -1;
    int last_wr_cyc = 0;
    int done_seen   = 0;
    int last_csum   = 0;

    always @(posedge Clock_50) cyc++;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic int clip_ref(input logic [31:0] v);
        int s;
        s = $signed(v[31:16]);
        if (s < 0) return 0;
        if (s > 255) return 255;
        return s;
    endfunction

    function automatic logic [31:0] rand_result();
        logic [15:0] hi;
        int          tmp;
        case ($urandom_range(0, 3))
            0: hi = 16'($urandom_range(0, 255));
            1: begin
                tmp = $urandom_range(1, 3000);
                hi  = 16'(-tmp);
            end
            2: hi = 16'($urandom_range(256, 32767));
            default: hi = 16'($urandom);
        endcase
        return {hi, 16'($urandom)};
    endfunction

    // ---------------- monitor ----------------
    wr_t  m_wr;
    blk_t m_blk;

    always @(negedge Clock_50) begin
        if (Resetn) begin
            if (int'(bw.DPRAM_read_address) > rd_max) rd_max = int'(bw.DPRAM_read_address);
            if (bw.busy) busy_cnt++;
            if (!bw.SRAM_we_n) begin
                blk_writes++;
                last_wr_cyc = cyc;
                sram[int'(bw.SRAM_address)] = bw.SRAM_write_data;
                if (int'(bw.SRAM_address) > max_wr_addr) max_wr_addr = int'(bw.SRAM_address);
                if (first_lat < 0) begin
                    first_lat = cyc - start_mark;
                    check("first write latency", first_lat, 3);
                    check("busy during write", bw.busy, 1);
                end
                if (exp_wr_q.size() == 0) begin
                    check("write with empty scoreboard", exp_wr_q.size(), 1);
                end else begin
                    m_wr = exp_wr_q.pop_front();
                    check("write address", bw.SRAM_address, m_wr.addr);
                    check("write data", bw.SRAM_write_data, m_wr.data);
                end
            end
            if (bw.done) begin
                done_seen++;
                if (exp_blk_q.size() == 0) begin
                    check("done with empty scoreboard", exp_blk_q.size(), 1);
                end else begin
                    m_blk = exp_blk_q.pop_front();
                    check("done latency", cyc - start_mark, m_blk.delta);
                    check("writes per block", blk_writes, m_blk.writes);
                    check("busy low at done", bw.busy, 0);
                    check("busy seen", busy_cnt > 0, m_blk.busy_expected);
                    check("dpram address max", rd_max, m_blk.rd_max);
                    check("leftover expected writes", exp_wr_q.size(), 0);
                    if (m_blk.writes > 0) check("last write to done", cyc - last_wr_cyc, 1);
`ifdef BLOCK_WRITER_CHECKSUM_EN
                    check("checksum at done", bw.checksum, m_blk.csum);
`endif
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called at posedge+1 with the DUT idle.
    task automatic issue_block(input int col, input int row);
        blk_t b;
        wr_t  w;
        int   csum;
        bit   ok;
        ok   = (col < N_COLS) && (row < N_ROWS);
        csum = 0;
        if (ok) begin
            for (int k = 0; k < 32; k++) begin
                w.data = clip_ref(dpram[RES_OFF + 2*k]) * 256 + clip_ref(dpram[RES_OFF + 2*k + 1]);
                w.addr = (row*8 + k/4) * ROW_WORDS + col*4 + (k % 4);
                csum   = (csum + w.data) % 65536;
                exp_wr_q.push_back(w);
            end
            last_csum = csum;
        end
        b.delta         = ok ? 66 : 1;
        b.writes        = ok ? 32 : 0;
        b.rd_max        = ok ? RES_OFF + 63 : RES_OFF;
        b.csum          = last_csum;
        b.busy_expected = ok;
        exp_blk_q.push_back(b);

        blk_writes  = 0;
        busy_cnt    = 0;
        rd_max      = 0;
        max_wr_addr = -1;
        first_lat   = -1;
        bw.block_col = 6'(col);
        bw.block_row = 5'(row);
        bw.start     = 1'b1;
        start_mark   = cyc;
        @(posedge Clock_50);
        #1;
        bw.start     = 1'b0;
        // Index changes after acceptance must not affect the block.
        bw.block_col = 6'($urandom);
        bw.block_row = 5'($urandom);
    endtask

    task automatic wait_done(input string name);
        int seen0;
        seen0 = done_seen;
        for (int i = 0; i < 200; i++) begin
            @(posedge Clock_50);
            #1;
            if (done_seen != seen0) break;
        end
        check({"done pulses: ", name}, done_seen - seen0, 1);
    endtask

    task automatic wait_write10(input string name);
        for (int i = 0; i < 200; i++) begin
            @(posedge Clock_50);
            #1;
            if (blk_writes == 10 && !bw.SRAM_we_n) break;
        end
        check({"reached write 10: ", name}, blk_writes, 10);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 64; i++) dpram[RES_OFF + i] = rand_result();
    endtask

    int addr10;

    initial begin
        for (int i = 0; i < 512; i++) dpram[i] = 32'd0;
        bw.start     = 1'b0;
        bw.block_col = 6'd0;
        bw.block_row = 5'd0;

        // Reset state.
        #25;
        check("reset we_n", bw.SRAM_we_n, 1);
        check("reset busy", bw.busy, 0);
        check("reset done", bw.done, 0);
        check("reset sram address", bw.SRAM_address, 0);
        check("reset write data", bw.SRAM_write_data, 0);
        check("reset dpram address", bw.DPRAM_read_address, RES_OFF);
        @(posedge Clock_50);
        #1;
        Resetn = 1'b1;
        @(posedge Clock_50);
        #1;

        // Ramp block at the origin.
        for (int i = 0; i < 64; i++) dpram[RES_OFF + i] = 32'(i) << 16;
        sram.delete();
        issue_block(0, 0);
        wait_done("ramp");
        check("ramp word0", sram.exists(0) ? int'(sram[0]) : -1, 16'h0001);
        check("ramp word31", sram.exists(1123) ? int'(sram[1123]) : -1, 16'h3E3F);

        // Saturation both ways.
        for (int i = 0; i < 64; i++) dpram[RES_OFF + i] = (i % 2 == 0) ? (-32'sd5 <<< 16) : (32'd300 << 16);
        issue_block(17, 11);
        wait_done("clip");

        // Bottom-right block of the plane.
        fill_random();
        issue_block(39, 29);
        wait_done("last block");
        check("last legal word", max_wr_addr, 38399);

        // Out-of-range requests.
        issue_block(40, 0);
        wait_done("reject col");
        issue_block(5, 30);
        wait_done("reject row");

        // Start while busy is ignored.
        fill_random();
        issue_block(12, 3);
        wait_write10("busy start");
        bw.start     = 1'b1;
        bw.block_col = 6'd7;
        bw.block_row = 5'd2;
        @(posedge Clock_50);
        #1;
        bw.start = 1'b0;
        wait_done("busy start");

        // Random blocks.
        for (int n = 0; n < 6; n++) begin
            fill_random();
            issue_block($urandom_range(0, N_COLS - 1), $urandom_range(0, N_ROWS - 1));
            wait_done("random");
        end

        // Reset during write #10.
        fill_random();
        sram.delete();
        issue_block(21, 14);
        wait_write10("reset");
        addr10 = int'(bw.SRAM_address);
        Resetn = 1'b0;
        #1;
        check("we_n released by reset", bw.SRAM_we_n, 1);
        check("busy cleared by reset", bw.busy, 0);
        check("dpram address after reset", bw.DPRAM_read_address, RES_OFF);
        exp_wr_q.delete();
        exp_blk_q.delete();
        repeat (2) @(posedge Clock_50);
        #1;
        Resetn = 1'b1;
        check("sram words after reset", sram.num(), 10);
        check("write 10 not committed", sram.exists(addr10), 0);
        @(posedge Clock_50);
        #1;

        // Normal operation after reset.
        fill_random();
        issue_block(1, 28);
        wait_done("after reset");

`ifdef BLOCK_WRITER_CHECKSUM_EN
        for (int i = 0; i < 64; i++) dpram[RES_OFF + i] = 32'd1 << 16;
        issue_block(9, 9);
        wait_done("checksum");
        check("checksum held", bw.checksum, 16'h2020);
`endif

        repeat (3) @(posedge Clock_50);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
